vote_session_ctrl: RTL and testbench

- Ballot-sequencing controller in front of the four-candidate vote tally datapath.
- Gates voting behind an officer "arm" handshake and debounces the four candidate buttons.
- Arbitrates simultaneous presses and issues exactly one single-cycle increment per armed ballot.
- In result mode, the tally is read-only and the controller selects which candidate count the datapath shows on the LEDs.

---
 rtl/vote_session_ctrl.sv | 159 +++++++++++++++
 tb/tb_vote_session_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: ballot sequencer in front of the four-candidate tally.
// Gates each ballot behind an officer arm edge, debounces the one-hot button
// pattern, rejects multi-presses, times out idle ballots and selects the
// candidate shown on the LEDs in result mode.
// Optional: define VOTE_AUDIT_EN to enable the saturating total_votes counter.
module vote_session_ctrl #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       arm,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       ready,
    output logic [3:0] vote_inc,
    output logic       reject,
    output logic       timeout,
    output logic       disp_en,
    output logic [1:0] disp_sel,
    output logic [7:0] total_votes
);

    localparam logic [7:0]  DMAX = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE, RESULTS} state_t;

    state_t      state, state_n;
    logic [7:0]  dcnt, dcnt_n;
    logic [15:0] tcnt, tcnt_n, tcnt_inc;
    logic [3:0]  pat, pat_n;
    logic        reject_n, timeout_n;
    logic [1:0]  sel_n;
    logic        arm_q;
    logic [3:0]  btn;
    logic        onehot;
    logic        arm_rise;
    logic [1:0]  btn_idx;

    assign btn      = {button4, button3, button2, button1};
    assign onehot   = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign arm_rise = arm && !arm_q;
    // Saturate so a long run of rejected presses cannot wrap past the limit.
    assign tcnt_inc = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;

    // Encode the one-hot button pattern to a candidate index.
    always_comb begin
        btn_idx = 2'd0;
        case (btn)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    // Next-state and counter updates; mode=1 overrides every ballot state.
    always_comb begin
        state_n   = state;
        dcnt_n    = dcnt;
        tcnt_n    = tcnt;
        pat_n     = pat;
        reject_n  = 1'b0;
        timeout_n = 1'b0;
        sel_n     = disp_sel;
        if (mode) begin
            state_n = RESULTS;
            dcnt_n  = 8'd0;
            tcnt_n  = 16'd0;
            if (state != RESULTS)
                sel_n = 2'd0;
            else if (onehot)
                sel_n = btn_idx;
        end else begin
            case (state)
                IDLE: if (arm_rise) begin
                    state_n = ARMED;
                    tcnt_n  = 16'd0;
                    dcnt_n  = 8'd0;
                end
                ARMED: begin
                    tcnt_n = tcnt_inc;
                    if (onehot) begin
                        state_n = DEBOUNCE;
                        dcnt_n  = 8'd1;
                        pat_n   = btn;
                    end else if (btn != 4'd0) begin
                        reject_n = 1'b1;
                    end else if (tcnt_inc >= TMAX) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if (btn == pat) begin
                        if (dcnt == DMAX)
                            state_n = COMMIT;
                        else
                            dcnt_n = dcnt + 8'd1;
                    end else begin
                        state_n = ARMED;
                        dcnt_n  = 8'd0;
                    end
                end
                COMMIT: begin
                    state_n = RELEASE;
                    dcnt_n  = 8'd0;
                end
                RELEASE: if (btn == 4'd0) state_n = IDLE;
                RESULTS: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dcnt     <= 8'd0;
            tcnt     <= 16'd0;
            pat      <= 4'd0;
            reject   <= 1'b0;
            timeout  <= 1'b0;
            disp_sel <= 2'd0;
            arm_q    <= 1'b0;
        end else begin
            state    <= state_n;
            dcnt     <= dcnt_n;
            tcnt     <= tcnt_n;
            pat      <= pat_n;
            reject   <= reject_n;
            timeout  <= timeout_n;
            disp_sel <= sel_n;
            arm_q    <= arm;
        end
    end

    assign ready    = (state == ARMED) || (state == DEBOUNCE);
    assign vote_inc = (state == COMMIT) ? pat : 4'd0;
    assign disp_en  = (state == RESULTS);

`ifdef VOTE_AUDIT_EN
    // Count committed ballots, holding at 255.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            total_votes <= 8'd0;
        else if (state == COMMIT && total_votes != 8'hFF)
            total_votes <= total_votes + 8'd1;
    end
`else
    assign total_votes = 8'd0;
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl with hand-computed expectations.
module tb_vote_session_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       arm;
    logic [3:0] btns;
    logic       ready;
    logic [3:0] vote_inc;
    logic       reject;
    logic       timeout;
    logic       disp_en;
    logic [1:0] disp_sel;
    logic [7:0] total_votes;

    int nvec  = 0;
    int nerr  = 0;
    int edgen = 0;
    int nvotes = 0;
    int nrej   = 0;
    int v0, r0;

    vote_session_ctrl #(.DEBOUNCE_CYCLES(10), .TIMEOUT_CYCLES(1000)) dut (
        .clock(clock), .reset(reset), .mode(mode), .arm(arm),
        .button1(btns[0]), .button2(btns[1]), .button3(btns[2]), .button4(btns[3]),
        .ready(ready), .vote_inc(vote_inc), .reject(reject), .timeout(timeout),
        .disp_en(disp_en), .disp_sel(disp_sel), .total_votes(total_votes)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edgen);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        edgen++;
        #1;
    endtask

    // Count increments and rejects between edges; increments must be one-hot.
    always @(negedge clock) begin
        if (vote_inc != 4'd0) begin
            nvotes++;
            chk("vote_onehot", 32'($countones(vote_inc)), 32'd1);
        end
        if (reject) nrej++;
    end

    task automatic arm_ballot();
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        chk("armed_ready", 32'(ready), 32'd1);
    endtask

    // Hold pattern from the next edge N; increment expected exactly at N+10.
    task automatic vote_burst(input logic [3:0] pat, input logic [3:0] exp);
        btns = pat;
        repeat (10) tick();
        chk("pre_commit", 32'(vote_inc), 32'd0);
        tick();
        chk("commit", 32'(vote_inc), 32'(exp));
        chk("commit_ready", 32'(ready), 32'd0);
        tick();
        chk("post_commit", 32'(vote_inc), 32'd0);
        repeat (3) tick();
        btns = 4'd0;
        tick();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; arm = 1'b0; btns = 4'd0;
        repeat (2) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_vote", 32'(vote_inc), 32'd0);
        chk("rst_rej", 32'(reject), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        chk("rst_disp", 32'({disp_en, disp_sel}), 32'd0);
        chk("rst_total", 32'(total_votes), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single clean vote for candidate 1
        v0 = nvotes;
        arm_ballot();
        vote_burst(4'b0001, 4'b0001);
        chk("t1_votes", 32'(nvotes - v0), 32'd1);
        tick();
        chk("t1_idle_ready", 32'(ready), 32'd0);

        // 2: short bounce then a real press
        v0 = nvotes;
        arm_ballot();
        btns = 4'b0010;
        repeat (5) tick();
        chk("t2_deb_ready", 32'(ready), 32'd1);
        btns = 4'd0;
        repeat (2) tick();
        chk("t2_bounce_novote", 32'(nvotes - v0), 32'd0);
        vote_burst(4'b0010, 4'b0010);
        chk("t2_votes", 32'(nvotes - v0), 32'd1);

        // 3: multi-press rejected, then single press accepted
        v0 = nvotes; r0 = nrej;
        arm_ballot();
        btns = 4'b0101;
        tick();
        chk("t3_reject", 32'(reject), 32'd1);
        chk("t3_ready", 32'(ready), 32'd1);
        vote_burst(4'b0100, 4'b0100);
        chk("t3_rej_count", 32'(nrej - r0), 32'd1);
        chk("t3_votes", 32'(nvotes - v0), 32'd1);

        // 4: idle ballot expires at entry edge + 1000
        v0 = nvotes;
        arm_ballot();
        repeat (999) tick();
        chk("t4_pre_to", 32'(timeout), 32'd0);
        chk("t4_pre_ready", 32'(ready), 32'd1);
        tick();
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_ready", 32'(ready), 32'd0);
        tick();
        chk("t4_to_pulse", 32'(timeout), 32'd0);
        vote_burst(4'b1000, 4'b0000);
        chk("t4_votes", 32'(nvotes - v0), 32'd0);

        // 5: results mode aborts a ballot and drives disp_sel
        v0 = nvotes;
        arm_ballot();
        btns = 4'b1000;
        repeat (6) tick();
        mode = 1'b1; btns = 4'd0;
        tick();
        chk("t5_disp_en", 32'(disp_en), 32'd1);
        chk("t5_sel0", 32'(disp_sel), 32'd0);
        chk("t5_ready", 32'(ready), 32'd0);
        btns = 4'b0100;
        tick();
        chk("t5_sel2", 32'(disp_sel), 32'd2);
        btns = 4'b0011;
        tick();
        chk("t5_sel_hold", 32'(disp_sel), 32'd2);
        btns = 4'd0; mode = 1'b0;
        tick();
        chk("t5_disp_off", 32'(disp_en), 32'd0);
        tick();
        chk("t5_no_rearm", 32'(ready), 32'd0);
        chk("t5_votes", 32'(nvotes - v0), 32'd0);
        mode = 1'b1;
        tick();
        chk("t5_sel_clear", 32'(disp_sel), 32'd0);
        mode = 1'b0;
        tick();
        arm_ballot();

        // async reset mid-debounce
        v0 = nvotes;
        btns = 4'b0001;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk("ar_ready", 32'(ready), 32'd0);
        chk("ar_vote", 32'(vote_inc), 32'd0);
        tick();
        reset = 1'b0; btns = 4'd0;
        tick();
        chk("ar_votes", 32'(nvotes - v0), 32'd0);
        chk("ar_total", 32'(total_votes), 32'd0);

        // 6: 260 committed ballots; audit counter saturates
        for (int i = 0; i < 260; i++) begin
            arm_ballot();
            btns = 4'b0001;
            repeat (12) tick();
            btns = 4'd0;
            repeat (2) tick();
            if (i == 99) begin
`ifdef VOTE_AUDIT_EN
                chk("t6_total100", 32'(total_votes), 32'd100);
`else
                chk("t6_total100", 32'(total_votes), 32'd0);
`endif
            end
        end
`ifdef VOTE_AUDIT_EN
        chk("t6_total_sat", 32'(total_votes), 32'd255);
`else
        chk("t6_total_sat", 32'(total_votes), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
